id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the pipelined datapath, directly upstream of the EX/MEM control register.
//  Captures decoded control and operands at the end of ID and presents them to EX one cycle later.
//  Supports a hold (stall) for load-use hazards and a bubble insert (flush) for taken branches/jumps.
//  Its mem_*/reg_write outputs feed the EX/MEM control register unchanged.
// PARAMETERS
//  DATA_W      32  width of PC, register operands and sign-extended immediate
//  REG_ADDR_W  5   width of the rs/rt/rd register specifiers
// PORTS
//  clk             in   1           rising-edge clock
//  rst             in   1           synchronous, active-high reset
//  stall           in   1           hold all outputs at current value
//  flush           in   1           insert bubble next cycle
//  valid_in        in   1           ID holds a real instruction
//  alu_src_in      in   1           ALU B operand select (0 = rd2, 1 = imm)
//  alu_op_in       in   3           ALU operation code
//  reg_dst_in      in   2           dest select (00 rt, 01 rd, 10 r31)
//  mem_write_in    in   1           store
//  mem_read_in     in   1           load
//  mem_to_reg_in   in   2           WB source (00 ALU, 01 mem, 10 PC+4)
//  reg_write_in    in   1           register file write
//  pc_plus4_in     in   DATA_W      PC+4 of the instruction
//  rd1_in, rd2_in  in   DATA_W      register file read data
//  imm_in          in   DATA_W      sign-extended immediate
//  rs_in, rt_in, rd_in in REG_ADDR_W register specifiers (for forwarding and dest select)
//  <name> (each *_in above, minus the suffix)  out  same width  registered copy
//  valid           out  1           EX holds a real instruction
//  bubble_cnt      out  16          saturating count of bubbles inserted by flush
// BEHAVIOUR
//  - All outputs are registered; latency is 1 cycle from *_in to output.
//  - Priority on each rising clk edge: rst > flush > stall > normal load.
//  - rst: every output goes to 0, including data fields, valid and bubble_cnt.
//  - flush, with or without stall:
//      - valid, alu_src, alu_op, reg_dst, mem_write, mem_read, mem_to_reg, reg_write -> 0.
//      - Data fields (pc_plus4, rd1, rd2, imm, rs, rt, rd) hold their current values.
//      - bubble_cnt increments, saturating at 16'hFFFF with no wrap.
//  - stall without flush: all outputs hold, including valid and bubble_cnt.
//  - Normal load: every output takes its *_in value in the same edge.
//  - valid_in = 0 on a normal load: control outputs load 0 regardless of inputs, so no stray write occurs.
//    Data fields still load.
//  - A bubble has reg_write = mem_write = mem_read = 0, so downstream stages see no architectural effect.
//  - Reset asserted mid-stall or mid-flush: reset wins on that edge.
//    Normal operation resumes on the first edge after rst deasserts.
//  - No combinational path from any input to any output.
// STRUCTURE
//  - Shared package holds:
//      - widths: CTRL_W = 11 bits of control, ALU_OP_W = 3
//      - encodings: ALU op codes, REG_DST_*, MEM_TO_REG_ALU/MEM/PC4
//  - Natural sub-module: pipe_reg, a WIDTH-parameterised register with en (load) and clr (zero).
//      - Instance 1 (control + valid): clr = flush.
//      - Instance 2 (data): en = ~stall & ~flush, clr never asserted except by rst.
//  - bubble_cnt is a small saturating counter in the top module.
// TESTING
//  1. rst = 1 for 2 cycles with all inputs 1s -> every output 0, bubble_cnt = 0.
//  2. Load alu_op = 3'b010, reg_write = 1, rd1 = 32'h1234, valid_in = 1 -> outputs match after 1 edge.
//  3. stall = 1 for 3 cycles while inputs change -> outputs frozen at prior values, bubble_cnt unchanged.
//  4. flush = 1 with stall = 1 and reg_write_in = 1:
//     -> valid = 0, all control 0, rd1 unchanged, bubble_cnt +1.
//  5. Preload bubble_cnt to 16'hFFFE via 2 flushes from a forced state, then flush x3 -> holds 16'hFFFF.
//  6. valid_in = 0 with mem_write_in = 1 -> mem_write = 0 next cycle, imm still loaded.
//     rst asserted during stall -> all outputs 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared widths, encodings and the packed control bundle for the ID/EX stage.
package id_ex_stage_pkg;

  localparam int CTRL_W   = 11;
  localparam int ALU_OP_W = 3;

  // ALU operation codes.
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b111;

  // Destination register select.
  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  // Write-back source select.
  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC4 = 2'b10;

  // Decoded control carried from ID into EX (CTRL_W bits wide).
  typedef struct packed {
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          reg_dst;
    logic                mem_write;
    logic                mem_read;
    logic [1:0]          mem_to_reg;
    logic                reg_write;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_pipe_reg.sv
// Generic pipeline register: synchronous reset, clear-to-zero and load enable.
// Priority on each edge: rst > clr > en.
module id_ex_stage_pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register with reset/clear/load priority; holds when nothing is asserted.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so
    // chained registers behave as a pipeline instead of racing through in one step.
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Control (with valid) and data travel in separate
// registers so a flush can zero control while the data fields keep their value.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  alu_src_in,
  input  logic [ALU_OP_W-1:0]   alu_op_in,
  input  logic [1:0]            reg_dst_in,
  input  logic                  mem_write_in,
  input  logic                  mem_read_in,
  input  logic [1:0]            mem_to_reg_in,
  input  logic                  reg_write_in,
  input  logic [DATA_W-1:0]     pc_plus4_in,
  input  logic [DATA_W-1:0]     rd1_in,
  input  logic [DATA_W-1:0]     rd2_in,
  input  logic [DATA_W-1:0]     imm_in,
  input  logic [REG_ADDR_W-1:0] rs_in,
  input  logic [REG_ADDR_W-1:0] rt_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  valid,
  output logic                  alu_src,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic [1:0]            reg_dst,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [1:0]            mem_to_reg,
  output logic                  reg_write,
  output logic [DATA_W-1:0]     pc_plus4,
  output logic [DATA_W-1:0]     rd1,
  output logic [DATA_W-1:0]     rd2,
  output logic [DATA_W-1:0]     imm,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rt,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [15:0]           bubble_cnt
);

  localparam int DATA_BUS_W = 4 * DATA_W + 3 * REG_ADDR_W;

  ctrl_t                 ctrl_d;
  ctrl_t                 ctrl_q;
  logic [CTRL_W:0]       ctrl_vq;
  logic [DATA_BUS_W-1:0] data_q;

  // Gate control with valid_in so an empty ID slot can never cause a write.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives ctrl_d,
    // which is what keeps this combinational block from inferring a latch.
    ctrl_d = '0;
    if (valid_in) begin
      ctrl_d.alu_src    = alu_src_in;
      ctrl_d.alu_op     = alu_op_in;
      ctrl_d.reg_dst    = reg_dst_in;
      ctrl_d.mem_write  = mem_write_in;
      ctrl_d.mem_read   = mem_read_in;
      ctrl_d.mem_to_reg = mem_to_reg_in;
      ctrl_d.reg_write  = reg_write_in;
    end
  end

  // Control and valid: flush zeroes them (bubble), stall holds them.
  id_ex_stage_pipe_reg #(.WIDTH(CTRL_W + 1)) u_ctrl_reg (
    .clk (clk),
    .rst (rst),
    .en  (~stall),
    .clr (flush),
    .d   ({valid_in, ctrl_d}),
    .q   (ctrl_vq)
  );

  // Data fields: hold through both stall and flush; only reset clears them.
  id_ex_stage_pipe_reg #(.WIDTH(DATA_BUS_W)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .en  (~stall & ~flush),
    .clr (1'b0),
    .d   ({pc_plus4_in, rd1_in, rd2_in, imm_in, rs_in, rt_in, rd_in}),
    .q   (data_q)
  );

  assign valid  = ctrl_vq[CTRL_W];
  assign ctrl_q = ctrl_t'(ctrl_vq[CTRL_W-1:0]);

  assign alu_src    = ctrl_q.alu_src;
  assign alu_op     = ctrl_q.alu_op;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_write  = ctrl_q.mem_write;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;

  assign {pc_plus4, rd1, rd2, imm, rs, rt, rd} = data_q;

  // Saturating count of bubbles inserted by flush; stall alone never counts.
  always_ff @(posedge clk) begin
    if (rst)                                   bubble_cnt <= '0;
    else if (flush && bubble_cnt != 16'hFFFF)  bubble_cnt <= bubble_cnt + 16'd1;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes the expected post-edge
// state from a rule-level model; a negedge monitor pops and compares.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic [1:0]  reg_dst;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  mem_to_reg;
    logic        reg_write;
    logic [31:0] pc_plus4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] bubble_cnt;
  } out_t;

  logic clk = 1'b0;
  logic rst, stall, flush, valid_in, alu_src_in, mem_write_in, mem_read_in, reg_write_in;
  logic [2:0]  alu_op_in;
  logic [1:0]  reg_dst_in, mem_to_reg_in;
  logic [31:0] pc_plus4_in, rd1_in, rd2_in, imm_in;
  logic [4:0]  rs_in, rt_in, rd_in;

  logic valid, alu_src, mem_write, mem_read, reg_write;
  logic [2:0]  alu_op;
  logic [1:0]  reg_dst, mem_to_reg;
  logic [31:0] pc_plus4, rd1, rd2, imm;
  logic [4:0]  rs, rt, rd;
  logic [15:0] bubble_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  out_t model;
  out_t exp_q[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .alu_src_in(alu_src_in), .alu_op_in(alu_op_in), .reg_dst_in(reg_dst_in),
    .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .pc_plus4_in(pc_plus4_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .valid(valid), .alu_src(alu_src), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_write(mem_write), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .pc_plus4(pc_plus4), .rd1(rd1), .rd2(rd2), .imm(imm),
    .rs(rs), .rt(rt), .rd(rd), .bubble_cnt(bubble_cnt)
  );

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Rule-level model of what EX should see after the coming edge.
  task automatic model_edge();
    if (rst) begin
      model = '0;
    end else if (flush) begin
      model.valid = 0; model.alu_src = 0; model.alu_op = 0; model.reg_dst = 0;
      model.mem_write = 0; model.mem_read = 0; model.mem_to_reg = 0; model.reg_write = 0;
      if (model.bubble_cnt < 16'hFFFF) model.bubble_cnt = model.bubble_cnt + 16'd1;
    end else if (!stall) begin
      model.valid      = valid_in;
      model.alu_src    = valid_in ? alu_src_in    : 1'b0;
      model.alu_op     = valid_in ? alu_op_in     : 3'd0;
      model.reg_dst    = valid_in ? reg_dst_in    : 2'd0;
      model.mem_write  = valid_in ? mem_write_in  : 1'b0;
      model.mem_read   = valid_in ? mem_read_in   : 1'b0;
      model.mem_to_reg = valid_in ? mem_to_reg_in : 2'd0;
      model.reg_write  = valid_in ? reg_write_in  : 1'b0;
      model.pc_plus4 = pc_plus4_in; model.rd1 = rd1_in; model.rd2 = rd2_in;
      model.imm = imm_in; model.rs = rs_in; model.rt = rt_in; model.rd = rd_in;
    end
  endtask

  // One clock: inputs were set before the edge; push the expectation after it.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    exp_q.push_back(model);
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    valid_in = 1'($urandom_range(0, 1)); alu_src_in = 1'($urandom_range(0, 1));
    alu_op_in = 3'($urandom); reg_dst_in = 2'($urandom_range(0, 2));
    mem_write_in = 1'($urandom_range(0, 1)); mem_read_in = 1'($urandom_range(0, 1));
    mem_to_reg_in = 2'($urandom_range(0, 2)); reg_write_in = 1'($urandom_range(0, 1));
    pc_plus4_in = $urandom; rd1_in = $urandom; rd2_in = $urandom; imm_in = $urandom;
    rs_in = 5'($urandom); rt_in = 5'($urandom); rd_in = 5'($urandom);
  endtask

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t e;
      e = exp_q.pop_front();
      check("ctrl", 192'({valid, alu_src, alu_op, reg_dst, mem_write, mem_read, mem_to_reg, reg_write}),
            192'({e.valid, e.alu_src, e.alu_op, e.reg_dst, e.mem_write, e.mem_read, e.mem_to_reg, e.reg_write}));
      check("data", 192'({pc_plus4, rd1, rd2, imm, rs, rt, rd}),
            192'({e.pc_plus4, e.rd1, e.rd2, e.imm, e.rs, e.rt, e.rd}));
      check("bubble_cnt", 192'(bubble_cnt), 192'(e.bubble_cnt));
    end
  end

  initial begin
    model = '0;
    // Reset with every input driven high.
    rst = 1; stall = 1; flush = 1; valid_in = 1; alu_src_in = 1; alu_op_in = '1;
    reg_dst_in = '1; mem_write_in = 1; mem_read_in = 1; mem_to_reg_in = '1;
    reg_write_in = 1; pc_plus4_in = '1; rd1_in = '1; rd2_in = '1; imm_in = '1;
    rs_in = '1; rt_in = '1; rd_in = '1;
    @(negedge clk);
    cycle(); cycle();

    // Plain load of a valid ALU instruction.
    rst = 0; stall = 0; flush = 0;
    rand_inputs();
    valid_in = 1; alu_op_in = 3'b010; reg_write_in = 1; rd1_in = 32'h1234;
    cycle();

    // Stall three cycles while inputs churn.
    stall = 1;
    repeat (3) begin rand_inputs(); cycle(); end

    // Flush with stall and a live reg_write request.
    flush = 1; reg_write_in = 1; valid_in = 1;
    cycle();
    flush = 0; stall = 0;

    // Counter saturation from a preloaded value.
    #1 force dut.bubble_cnt = 16'hFFFC;
    #1 release dut.bubble_cnt;
    model.bubble_cnt = 16'hFFFC;
    flush = 1;
    repeat (5) begin rand_inputs(); cycle(); end
    flush = 0;

    // Invalid instruction must not carry a store; data still loads.
    rand_inputs();
    valid_in = 0; mem_write_in = 1; imm_in = 32'hCAFE_F00D;
    cycle();

    // Reset wins over an active stall, then resume.
    stall = 1; rand_inputs(); cycle();
    rst = 1; cycle();
    rst = 0; stall = 0; rand_inputs(); cycle();

    // Randomized traffic mixing stall, flush and occasional reset.
    repeat (400) begin
      rand_inputs();
      stall = ($urandom_range(0, 99) < 25);
      flush = ($urandom_range(0, 99) < 15);
      rst   = ($urandom_range(0, 99) < 3);
      cycle();
    end
    rst = 0; stall = 0; flush = 0;

    repeat (2) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
